// File: rtl/irq_pkg.sv
// Shared types and helpers for the vectored interrupt controller: FSM state encoding,
// default vector layout and the fixed-priority encoder.
package irq_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StTake    = 2'd1,
        StService = 2'd2,
        StReturn  = 2'd3
    } irq_state_e;

    localparam logic [9:0]  VEC_BASE_DEF   = 10'h3F0;
    localparam int unsigned VEC_STRIDE_DEF = 4;

    // Lowest set index wins; returns 0 when nothing is set (caller gates on |req).
    function automatic logic [2:0] prio_enc(input logic [7:0] req);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// Per-line request conditioning: optional 2-flop synchronizer (IRQ_SYNC_EN) followed by a
// rising-edge detector producing a one-cycle rise pulse.
module irq_edge_sync #(
    parameter int unsigned NIRQ = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NIRQ-1:0] irq,
    output logic [NIRQ-1:0] rise
);

    logic [NIRQ-1:0] irq_s;
    logic [NIRQ-1:0] irq_q, irq_d;

`ifdef IRQ_SYNC_EN
    logic [NIRQ-1:0] sync1_q, sync1_d;
    logic [NIRQ-1:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = irq;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign irq_s = sync2_q;
`else
    assign irq_s = irq;
`endif

    always_comb begin
        irq_d = irq_s;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q <= '0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign rise = irq_s & ~irq_q;

endmodule

// File: rtl/irq_ctrl.sv
// Vectored interrupt controller: latches edge requests, arbitrates by fixed priority and
// sequences push / vector / pop on the shared return stack. IRQ_SYNC_EN adds input synchronizers.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int unsigned     NIRQ       = 4,
    parameter int unsigned     PC_W       = 10,
    parameter logic [PC_W-1:0] VEC_BASE   = PC_W'(VEC_BASE_DEF),
    parameter int unsigned     VEC_STRIDE = VEC_STRIDE_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NIRQ-1:0] irq,
    input  logic            ie_set,
    input  logic            ie_clr,
    input  logic            mask_we,
    input  logic [NIRQ-1:0] mask_wd,
    input  logic            reti,
    input  logic            cpu_stack_op,
    input  logic [PC_W-1:0] pc_ret,
    output logic            push,
    output logic [PC_W-1:0] push_data,
    output logic            pop,
    output logic            pc_sel,
    output logic [PC_W-1:0] pc_vec,
    output logic            in_service,
    output logic [2:0]      active_id,
    output logic [NIRQ-1:0] pending
);

    irq_state_e      state_q, state_d;
    logic            gie_q, gie_d;
    logic [NIRQ-1:0] mask_q, mask_d;
    logic [NIRQ-1:0] pend_q, pend_d;
    logic [2:0]      id_q, id_d;
    logic            push_q, push_d;
    logic            pop_q, pop_d;
    logic            pc_sel_q, pc_sel_d;
    logic [PC_W-1:0] vec_q, vec_d;
    logic            in_service_q, in_service_d;

    logic [NIRQ-1:0] rise;
    logic [NIRQ-1:0] elig;
    logic [2:0]      idx;
    logic [PC_W-1:0] vec;

    irq_edge_sync #(
        .NIRQ (NIRQ)
    ) u_edge (
        .clk   (clk),
        .reset (reset),
        .irq   (irq),
        .rise  (rise)
    );

    assign elig = pend_q & mask_q;
    assign idx  = prio_enc(8'(elig));
    // Vector address wraps modulo 2^PC_W.
    assign vec  = VEC_BASE + PC_W'(32'(idx) * VEC_STRIDE);

    always_comb begin
        state_d      = state_q;
        gie_d        = gie_q;
        mask_d       = mask_we ? mask_wd : mask_q;
        pend_d       = pend_q | rise;
        id_d         = id_q;
        push_d       = 1'b0;
        pop_d        = 1'b0;
        pc_sel_d     = 1'b0;
        vec_d        = '0;
        in_service_d = in_service_q;

        if (ie_set) begin
            gie_d = 1'b1;
        end
        if (ie_clr) begin
            gie_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (gie_q && (|elig) && !cpu_stack_op) begin
                    state_d  = StTake;
                    id_d     = idx;
                    push_d   = 1'b1;
                    pc_sel_d = 1'b1;
                    vec_d    = vec;
                end
            end
            StTake: begin
                // A fresh edge on the serviced line re-arms it even though it is cleared here.
                pend_d       = (pend_q & ~(NIRQ'(1) << id_q)) | rise;
                gie_d        = 1'b0;
                in_service_d = 1'b1;
                state_d      = StService;
            end
            StService: begin
                if (reti) begin
                    state_d = StReturn;
                    pop_d   = 1'b1;
                end
            end
            StReturn: begin
                gie_d        = 1'b1;
                in_service_d = 1'b0;
                state_d      = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            gie_q        <= 1'b0;
            mask_q       <= '0;
            pend_q       <= '0;
            id_q         <= 3'd0;
            push_q       <= 1'b0;
            pop_q        <= 1'b0;
            pc_sel_q     <= 1'b0;
            vec_q        <= '0;
            in_service_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            gie_q        <= gie_d;
            mask_q       <= mask_d;
            pend_q       <= pend_d;
            id_q         <= id_d;
            push_q       <= push_d;
            pop_q        <= pop_d;
            pc_sel_q     <= pc_sel_d;
            vec_q        <= vec_d;
            in_service_q <= in_service_d;
        end
    end

    // The return address is the live pc_ret of the TAKE cycle itself.
    assign push_data  = push_q ? pc_ret : '0;
    assign push       = push_q;
    assign pop        = pop_q;
    assign pc_sel     = pc_sel_q;
    assign pc_vec     = vec_q;
    assign in_service = in_service_q;
    assign active_id  = id_q;
    assign pending    = pend_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: stimulus runs a behavioural model and queues expectations,
// a negedge monitor compares them. A second instance with VEC_BASE=10'h3FC covers vector wrap.
`timescale 1ns/1ps
module tb_irq_ctrl;

`ifdef IRQ_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq;
    logic       ie_set, ie_clr, mask_we, reti, cpu_stack_op;
    logic [3:0] mask_wd;
    logic [9:0] pc_ret;

    logic       push, pop, pc_sel, in_service;
    logic [9:0] push_data, pc_vec;
    logic [2:0] active_id;
    logic [3:0] pending;

    logic       w_push, w_pop, w_pc_sel, w_in_service;
    logic [9:0] w_push_data, w_pc_vec;
    logic [2:0] w_active_id;
    logic [3:0] w_pending;

    irq_ctrl #(
        .NIRQ       (4),
        .PC_W       (10),
        .VEC_BASE   (10'h3F0),
        .VEC_STRIDE (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .irq          (irq),
        .ie_set       (ie_set),
        .ie_clr       (ie_clr),
        .mask_we      (mask_we),
        .mask_wd      (mask_wd),
        .reti         (reti),
        .cpu_stack_op (cpu_stack_op),
        .pc_ret       (pc_ret),
        .push         (push),
        .push_data    (push_data),
        .pop          (pop),
        .pc_sel       (pc_sel),
        .pc_vec       (pc_vec),
        .in_service   (in_service),
        .active_id    (active_id),
        .pending      (pending)
    );

    irq_ctrl #(
        .NIRQ       (4),
        .PC_W       (10),
        .VEC_BASE   (10'h3FC),
        .VEC_STRIDE (4)
    ) dut_w (
        .clk          (clk),
        .reset        (reset),
        .irq          (irq),
        .ie_set       (ie_set),
        .ie_clr       (ie_clr),
        .mask_we      (mask_we),
        .mask_wd      (mask_wd),
        .reti         (reti),
        .cpu_stack_op (cpu_stack_op),
        .pc_ret       (pc_ret),
        .push         (w_push),
        .push_data    (w_push_data),
        .pop          (w_pop),
        .pc_sel       (w_pc_sel),
        .pc_vec       (w_pc_vec),
        .in_service   (w_in_service),
        .active_id    (w_active_id),
        .pending      (w_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       is_push;
        int         cyc;
        logic [9:0] data;
        logic [9:0] vec;
        logic [9:0] wvec;
        logic [2:0] id;
    } ev_t;

    typedef struct {
        logic       in_service;
        logic [2:0] id;
        logic [3:0] pend;
        logic       pc_sel;
        logic [9:0] vec;
        logic [9:0] pdata;
    } st_t;

    ev_t ev_q[$];
    st_t st_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cur_cycle = 0;
    bit  saw_wrap = 1'b0;

    // Reference model: handler progress flags, architectural registers, input history.
    bit         m_take, m_serv, m_ret;
    logic       m_gie;
    logic [3:0] m_mask, m_pend, m_prev;
    logic [2:0] m_id;
    logic [3:0] m_hist [0:2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cur_cycle);
        end
    endtask

    function automatic logic [9:0] vec_of(input int base, input int id);
        return 10'((base + id * 4) % 1024);
    endfunction

    function automatic logic [2:0] lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    task automatic model_clear();
        m_take = 0; m_serv = 0; m_ret = 0;
        m_gie = 0; m_mask = 0; m_pend = 0; m_prev = 0; m_id = 0;
        for (int i = 0; i < 3; i++) m_hist[i] = 4'd0;
    endtask

    task automatic model_step();
        st_t        s;
        ev_t        e;
        logic [3:0] irq_s, rise, elig, n_pend;
        logic       n_gie;
        if (reset) begin
            model_clear();
            s = '{in_service: 0, id: 0, pend: 0, pc_sel: 0, vec: 0, pdata: 0};
            st_q.push_back(s);
            return;
        end
        s.in_service = m_serv || m_ret;
        s.id         = m_id;
        s.pend       = m_pend;
        s.pc_sel     = m_take;
        s.vec        = m_take ? vec_of(10'h3F0, int'(m_id)) : 10'd0;
        s.pdata      = m_take ? pc_ret : 10'd0;
        st_q.push_back(s);
        if (m_take) begin
            e = '{is_push: 1, cyc: cur_cycle, data: pc_ret, vec: vec_of(10'h3F0, int'(m_id)),
                  wvec: vec_of(10'h3FC, int'(m_id)), id: m_id};
            ev_q.push_back(e);
        end
        if (m_ret) begin
            e = '{is_push: 0, cyc: cur_cycle, data: 0, vec: 0, wvec: 0, id: m_id};
            ev_q.push_back(e);
        end

        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = irq;
        irq_s  = m_hist[SYNC_LAT];
        rise   = irq_s & ~m_prev;
        m_prev = irq_s;
        elig   = m_pend & m_mask;

        n_gie = m_gie;
        if (ie_set) n_gie = 1;
        if (ie_clr) n_gie = 0;
        n_pend = m_pend | rise;
        if (m_take) begin
            n_pend = (m_pend & ~(4'b0001 << m_id)) | rise;
            n_gie  = 0;
            m_take = 0;
            m_serv = 1;
        end else if (m_serv) begin
            if (reti) begin
                m_serv = 0;
                m_ret  = 1;
            end
        end else if (m_ret) begin
            n_gie = 1;
            m_ret = 0;
        end else if (m_gie && elig != 0 && !cpu_stack_op) begin
            m_take = 1;
            m_id   = lowest(elig);
        end
        m_gie  = n_gie;
        m_pend = n_pend;
        if (mask_we) m_mask = mask_wd;
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        cur_cycle++;
        ie_set = 0; ie_clr = 0; mask_we = 0; reti = 0; cpu_stack_op = 0;
    endtask

    always @(negedge clk) begin
        st_t s;
        ev_t e;
        if (st_q.size() > 0) begin
            s = st_q.pop_front();
            chk("in_service", in_service, s.in_service);
            chk("active_id", active_id, s.id);
            chk("pending", pending, s.pend);
            chk("pc_sel", pc_sel, s.pc_sel);
            chk("pc_vec", pc_vec, s.vec);
            chk("push_data", push_data, s.pdata);
            chk("wrap_pending", w_pending, s.pend);
        end
        if (push || pop) begin
            if (ev_q.size() == 0) begin
                chk("unexpected_strobe", {push, pop}, 2'b00);
            end else begin
                e = ev_q.pop_front();
                chk("strobe_cycle", cur_cycle, e.cyc);
                chk("strobe_kind", {push, pop}, e.is_push ? 2'b10 : 2'b01);
                if (e.is_push) begin
                    chk("push_data_ev", push_data, e.data);
                    chk("pc_vec_ev", pc_vec, e.vec);
                    chk("active_id_ev", active_id, e.id);
                    chk("wrap_push", w_push, 1);
                    chk("wrap_vec", w_pc_vec, e.wvec);
                    if (e.id == 3'd1) saw_wrap = 1'b1;
                end else begin
                    chk("wrap_pop", w_pop, 1);
                end
            end
        end
        if (push && (pop || cpu_stack_op)) begin
            chk("stack_conflict", {push, pop, cpu_stack_op}, 3'b100);
        end
    end

    initial begin
        reset = 1; irq = 0; ie_set = 0; ie_clr = 0; mask_we = 0; mask_wd = 0;
        reti = 0; cpu_stack_op = 0; pc_ret = 0;
        model_clear();
        @(posedge clk);
        #1;
        repeat (2) cyc();
        reset = 0;
        cyc();

        // Basic take of line 2.
        mask_we = 1; mask_wd = 4'b1111; cyc();
        ie_set = 1; cyc();
        pc_ret = 10'h045; irq[2] = 1; repeat (8) cyc();
        reti = 1; cyc();
        repeat (4) cyc();
        irq = 0; repeat (2) cyc();

        // Priority: lines 1 and 3 together, 3 waits for the return of 1.
        pc_ret = 10'h100; irq = 4'b1010; repeat (8) cyc();
        reti = 1; cyc();
        repeat (8) cyc();
        reti = 1; cyc();
        repeat (4) cyc();
        irq = 0; repeat (2) cyc();

        // Masking, then ei/di collision.
        mask_we = 1; mask_wd = 4'b0001; cyc();
        irq[2] = 1; repeat (6) cyc();
        mask_we = 1; mask_wd = 4'b0100; repeat (6) cyc();
        reti = 1; cyc();
        repeat (3) cyc();
        irq = 0; cyc();
        ie_set = 1; ie_clr = 1; cyc();
        irq[2] = 1; repeat (6) cyc();
        ie_set = 1; repeat (6) cyc();
        reti = 1; cyc();
        repeat (3) cyc();
        irq = 0; repeat (2) cyc();

        // Stack conflict: eligible while the CPU owns the stack for 3 cycles.
        ie_clr = 1; cyc();
        irq[2] = 1; repeat (5) cyc();
        ie_set = 1; cyc();
        repeat (3) begin
            cpu_stack_op = 1; cyc();
        end
        repeat (3) cyc();
        reti = 1; cyc();
        repeat (3) cyc();
        reti = 1; cyc();
        repeat (2) cyc();
        irq = 0; repeat (2) cyc();

        // Reset while servicing; afterwards GIE=0 keeps requests pending.
        irq[0] = 1; repeat (7) cyc();
        reset = 1; repeat (2) cyc();
        reset = 0; cyc();
        irq = 0; mask_we = 1; mask_wd = 4'b1111; cyc();
        irq[3] = 1; repeat (6) cyc();
        irq = 0; cyc();

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 7) == 0) irq[b] = ~irq[b];
            end
            pc_ret  = 10'($urandom);
            ie_set  = ($urandom_range(0, 9) == 0);
            ie_clr  = ($urandom_range(0, 19) == 0);
            mask_we = ($urandom_range(0, 15) == 0);
            mask_wd = 4'($urandom);
            reti    = ($urandom_range(0, 5) == 0);
            cpu_stack_op = !m_take && !m_ret && ($urandom_range(0, 4) == 0);
            cyc();
        end
        reset = 0;
        repeat (3) cyc();

        @(negedge clk);
        #1;
        chk("ev_drain", ev_q.size(), 0);
        chk("wrap_seen", saw_wrap, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
Vectored interrupt controller for the 8-bit CPU. It latches edge-triggered interrupt requests and arbitrates between them by fixed priority. To take an interrupt it sequences the datapath: it pushes the return PC onto the 8-deep, 10-bit return stack, overrides the PC mux with a vector address, and on return-from-interrupt pops the stack. It sits beside the PC register, PC mux and return stack, and is driven by decoded ei/di/reti/mask-write instructions from the control unit.

Parameters:
NIRQ, 4, number of interrupt lines (1..8)
PC_W, 10, PC / stack entry width
VEC_BASE, 10'h3F0, address of vector 0
VEC_STRIDE, 4, address distance between consecutive vectors

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
irq  in  NIRQ  interrupt request lines; rising edge = request
ie_set  in  1  ei instruction: set global enable (GIE)
ie_clr  in  1  di instruction: clear GIE
mask_we  in  1  write per-line mask register
mask_wd  in  NIRQ  new mask value; 1 = line enabled
reti  in  1  return-from-interrupt decoded this cycle
cpu_stack_op  in  1  CPU call/ret is using the stack this cycle
pc_ret  in  PC_W  address of next sequential instruction (return address)
push  out  1  stack push strobe
push_data  out  PC_W  value to push
pop  out  1  stack pop strobe
pc_sel  out  1  1 = PC mux selects pc_vec
pc_vec  out  PC_W  vector address
in_service  out  1  handler active
active_id  out  3  index of the line being serviced
pending  out  NIRQ  latched requests

Behaviour:
- Reset is asynchronous. All registers go to 0: GIE=0, mask=0, pending=0, FSM=IDLE, and every output is 0.
- Edge detect: irq_s is registered into irq_q. The pending bit i is set on the clock edge where irq_s[i]=1 and irq_q[i]=0. Line i is eligible when pending[i] & mask[i].
- Taking an interrupt clears its pending bit. If a new edge arrives in the same cycle as the clear, the set wins.
- Priority is fixed: the lowest index wins.
- GIE: if ie_set and ie_clr are both asserted in one cycle, ie_clr wins.
- Vector: pc_vec = VEC_BASE + idx*VEC_STRIDE, truncated to PC_W bits (wraps).
- FSM states: IDLE, TAKE, SERVICE, RETURN.
- IDLE: when GIE & |eligible & !cpu_stack_op, go to TAKE and register idx into active_id. If cpu_stack_op is asserted, TAKE is deferred.
- TAKE (exactly 1 cycle):
  - push=1, push_data=pc_ret, pc_sel=1, pc_vec=vector.
  - Clear pending[idx]; GIE<=0; in_service<=1.
  - Next state is SERVICE.
- SERVICE: wait for reti, then go to RETURN. ei/di/mask writes are still accepted. Requests keep latching but are not taken (no nesting).
- RETURN (exactly 1 cycle): pop=1. The control unit loads the popped value into the PC. GIE<=1 and in_service<=0; next state is IDLE.
- Latency: an eligible pending bit in cycle n gives push/pc_sel in cycle n+1. The earliest next take is 1 cycle after RETURN.
- reti outside SERVICE is ignored (no pop); it is the CPU's own ret.
- push and pop are never asserted together and never in a cycle where cpu_stack_op=1.
- Stack overflow is the software's responsibility; the controller does not track depth.
- Reset in any state aborts the sequence and returns to IDLE with all outputs 0.

Optional Feature:
IRQ_SYNC_EN.
- Defined: each irq line passes through a 2-flop synchronizer before edge detect. Pending sets on the 3rd rising clk edge after irq rises.
- Undefined: irq_s = irq directly; inputs must be synchronous to clk. Pending sets on the 1st edge after irq rises.

Decomposition:
- Package irq_pkg:
  - FSM state enum (IDLE, TAKE, SERVICE, RETURN, 2-bit encoding)
  - default VEC_BASE and VEC_STRIDE constants
  - priority-encode function
- Sub-module irq_edge_sync: per-line optional synchronizer plus edge detect, producing a 1-cycle rise pulse.

Test Plan:
- Basic take:
  - Stimulus: mask=4'b1111, ei, pc_ret=10'h045, irq[2] rising.
  - Required: push=1 with push_data=10'h045, pc_sel=1, pc_vec=10'h3F8, active_id=2, pending[2] cleared, GIE=0.
  - Then reti → pop=1 for 1 cycle, GIE=1, in_service=0.
- Priority:
  - Stimulus: irq[3] and irq[1] rise in the same cycle.
  - Required: line 1 taken first (pc_vec=10'h3F4). After reti, line 3 is taken (10'h3FC) one cycle after RETURN.
- Masking and GIE:
  - Stimulus: mask=4'b0001 with irq[2] edge.
  - Required: pending[2]=1 but no take. After mask_wd=4'b0100 it is taken.
  - ie_set and ie_clr asserted together → GIE=0.
- Stack conflict:
  - Stimulus: cpu_stack_op=1 for 3 cycles while eligible.
  - Required: TAKE deferred until the cycle after cpu_stack_op drops; never push and CPU op in the same cycle.
  - reti in IDLE → no pop.
- Reset mid-operation:
  - Stimulus: assert reset while in SERVICE.
  - Required: all outputs 0, FSM=IDLE, pending=0; a later irq with GIE=0 is not taken.
- Wrap and sync:
  - Stimulus: VEC_BASE=10'h3FC, irq[1] taken.
  - Required: pc_vec=10'h000 (wrap).
  - With IRQ_SYNC_EN, pending sets 2 cycles later than without it.
